// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM encoding, default datapath width
// and the PC alignment helper.
package rv32i_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    // Instruction addresses are word aligned; low two bits are always cleared.
    function automatic logic [XLEN_DEFAULT-1:0] align_word(input logic [XLEN_DEFAULT-1:0] addr);
        return addr & ~(XLEN_DEFAULT'(2'b11));
    endfunction

endpackage

// File: rtl/pc_select.sv
// Next-PC selector: redirect from execute beats predictor, predictor beats
// sequential PC+4. The chosen value is returned word aligned.
module pc_select
    import rv32i_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            mispredict,
    input  logic [XLEN-1:0] mispredict_target,
    input  logic            predict_taken,
    input  logic [XLEN-1:0] predict_target,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(2'b11);

    logic [XLEN-1:0] sel_s;

    // Priority mux over the three candidate targets
    always_comb begin
        sel_s = pc_plus4;
        if (mispredict) begin
            sel_s = mispredict_target;
        end else if (predict_taken) begin
            sel_s = predict_target;
        end else begin
            sel_s = pc_plus4;
        end
    end

    assign next_pc = sel_s & ~ALIGN_MASK;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: keeps at most one imem request in flight, holds
// the fetched word for decode and steers the PC on redirects and predictions.
module fetch_controller
    import rv32i_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            evaluated_branch_mispredicted,
    input  logic [XLEN-1:0] evaluated_branch_result,
    input  logic            predicted_branch_taken,
    input  logic [XLEN-1:0] predicted_branch_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            if_ready
);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(2'b11);

    fetch_state_t    state_r;
    fetch_state_t    state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] pc_sel_s;
    logic            req_valid_r;
    logic            if_valid_r;
    logic [XLEN-1:0] if_pc_r;
    logic [31:0]     if_instr_r;
    logic            hold_accept_s;
    logic            pred_taken_s;
    logic            pc_load_s;
    logic            capture_s;

    // The predictor only matters when decode takes the held instruction.
    assign hold_accept_s = (state_r == S_HOLD) && if_ready;
    assign pred_taken_s  = hold_accept_s && predicted_branch_taken;
    assign pc_load_s     = evaluated_branch_mispredicted || hold_accept_s;
    assign pc_plus4_s    = pc_r + PC_STEP;

    pc_select #(.XLEN(XLEN)) u_pc_select (
        .mispredict        (evaluated_branch_mispredicted),
        .mispredict_target (evaluated_branch_result),
        .predict_taken     (pred_taken_s),
        .predict_target    (predicted_branch_target),
        .pc_plus4          (pc_plus4_s),
        .next_pc           (pc_sel_s)
    );

    // PC update: redirect in any state, or sequential/predicted step on decode accept
    always_comb begin
        pc_nxt_s = pc_r;
        if (pc_load_s) begin
            pc_nxt_s = pc_sel_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Fetch FSM next state; a redirect turns any in-flight response into one to drop
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            S_REQ: begin
                if (req_valid_r && imem_req_ready) begin
                    if (evaluated_branch_mispredicted) begin
                        state_nxt_s = S_DRAIN;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (evaluated_branch_mispredicted) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_HOLD;
                        capture_s   = 1'b1;
                    end
                end else if (evaluated_branch_mispredicted) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (evaluated_branch_mispredicted || if_ready) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s = S_REQ;
            end
        endcase
    end

    // State, PC and output registers; request valid stays low for the reset cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_REQ;
            pc_r        <= RESET_VECTOR & ~ALIGN_MASK;
            req_valid_r <= 1'b0;
            if_valid_r  <= 1'b0;
            if_pc_r     <= {XLEN{1'b0}};
            if_instr_r  <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            req_valid_r <= (state_nxt_s == S_REQ);
            if_valid_r  <= (state_nxt_s == S_HOLD);
            if (capture_s) begin
                if_pc_r    <= pc_r;
                if_instr_r <= imem_resp_data;
            end else begin
                if_pc_r    <= if_pc_r;
                if_instr_r <= if_instr_r;
            end
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign if_valid       = if_valid_r;
    assign if_pc          = if_pc_r;
    assign if_instr       = if_instr_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a transaction-level model predicts
// request addresses and delivered instructions; a monitor checks the DUT.
module tb_fetch_controller;
    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        evaluated_branch_mispredicted;
    logic [31:0] evaluated_branch_result;
    logic        predicted_branch_taken;
    logic [31:0] predicted_branch_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    always #5 clk = ~clk;

    fetch_controller #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .evaluated_branch_mispredicted (evaluated_branch_mispredicted),
        .evaluated_branch_result       (evaluated_branch_result),
        .predicted_branch_taken        (predicted_branch_taken),
        .predicted_branch_target       (predicted_branch_target),
        .imem_req_valid                (imem_req_valid),
        .imem_req_addr                 (imem_req_addr),
        .imem_req_ready                (imem_req_ready),
        .imem_resp_valid               (imem_resp_valid),
        .imem_resp_data                (imem_resp_data),
        .if_valid                      (if_valid),
        .if_pc                         (if_pc),
        .if_instr                      (if_instr),
        .if_ready                      (if_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a program counter plus "request in flight / wanted / held" facts
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t      exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_armed, m_out, m_want, m_hold;
    bit          m_acc, m_rsp, m_was_hold;

    initial begin
        m_pc = RV; m_req_pc = 32'h0; m_armed = 0; m_out = 0; m_want = 0; m_hold = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pc = RV; m_armed = 0; m_out = 0; m_want = 0; m_hold = 0;
                exp_q.delete();
            end else begin
                m_acc      = m_armed && !m_out && !m_hold && imem_req_ready;
                m_rsp      = m_out && imem_resp_valid;
                m_was_hold = m_hold;
                if (m_acc) begin
                    m_out = 1; m_want = 1; m_req_pc = m_pc;
                end
                if (m_rsp) begin
                    m_out = 0;
                    if (m_want && !evaluated_branch_mispredicted) begin
                        m_hold = 1;
                        exp_q.push_back({m_req_pc, instr_of(m_req_pc)});
                    end
                end
                if (evaluated_branch_mispredicted) m_want = 0;
                if (m_was_hold && (evaluated_branch_mispredicted || if_ready)) begin
                    m_hold = 0;
                    if (!evaluated_branch_mispredicted)
                        m_pc = predicted_branch_taken ? predicted_branch_target : m_pc + 32'd4;
                end
                if (evaluated_branch_mispredicted) m_pc = evaluated_branch_result;
                m_pc[1:0] = 2'b00;
                m_armed = 1;
            end
        end
    end

    // Monitor: compares DUT outputs against the model just after each falling edge
    fetch_t cur;
    bit     prev_v;
    initial begin
        prev_v = 0;
        cur    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("rst_req_valid", 32'(imem_req_valid), 32'd0);
                check("rst_if_valid", 32'(if_valid), 32'd0);
                check("rst_if_pc", if_pc, 32'd0);
                check("rst_if_instr", if_instr, 32'd0);
                prev_v = 0;
            end else begin
                check("req_valid", 32'(imem_req_valid), 32'(m_armed && !m_out && !m_hold));
                if (m_armed && !m_out && !m_hold) check("req_addr", imem_req_addr, m_pc);
                check("if_valid", 32'(if_valid), 32'(m_hold));
                if (if_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_instr: got pc %08h, none expected", if_pc);
                    end else begin
                        cur = exp_q.pop_front();
                        check("if_pc", if_pc, cur.pc);
                        check("if_instr", if_instr, cur.instr);
                    end
                end else if (if_valid) begin
                    check("if_pc_stable", if_pc, cur.pc);
                    check("if_instr_stable", if_instr, cur.instr);
                end
                prev_v = if_valid;
            end
        end
    end

    // Memory side of the bench: one pending request, answered when the stimulus says so
    bit          mem_pend = 0;
    logic [31:0] mem_addr = 32'h0;
    int          cyc = 0;

    task automatic step(input bit rdy, input bit give_resp, input bit mis, input logic [31:0] mis_t,
                        input bit pt, input logic [31:0] ptgt, input bit ifr, output bit acc);
        logic [31:0] a_addr;
        imem_req_ready                = rdy;
        imem_resp_valid               = give_resp && mem_pend;
        imem_resp_data                = imem_resp_valid ? instr_of(mem_addr) : 32'hDEAD_BEEF;
        evaluated_branch_mispredicted = mis;
        evaluated_branch_result       = mis_t;
        predicted_branch_taken        = pt;
        predicted_branch_target       = ptgt;
        if_ready                      = ifr;
        acc    = imem_req_valid && rdy;
        a_addr = imem_req_addr;
        @(posedge clk);
        if (imem_resp_valid) mem_pend = 0;
        if (acc) begin
            mem_pend = 1;
            mem_addr = a_addr;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic fetch_simple(input bit pt, input logic [31:0] ptgt, output int acc_cyc);
        bit a;
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, a);
        acc_cyc = cyc;
        check("fetch_accept", 32'(a), 32'd1);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, a);
        step(0, 0, 0, 32'h0, pt, ptgt, 1, a);
    endtask

    initial begin
        bit a;
        int c[3];
        int dummy;
        rst = 1'b1;
        evaluated_branch_mispredicted = 0; evaluated_branch_result = 32'h0;
        predicted_branch_taken = 0; predicted_branch_target = 32'h0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 32'h0; if_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, a);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RV);

        // Straight-line fetch 0x0, 0x4, 0x8 at one fetch per three cycles
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", imem_req_addr, 32'(i * 4));
            fetch_simple(0, 32'h0, c[i]);
        end
        check("seq_period_1", 32'(c[1] - c[0]), 32'd3);
        check("seq_period_2", 32'(c[2] - c[1]), 32'd3);

        // Predicted taken branch from 0x10 to 0x80
        fetch_simple(0, 32'h0, dummy);
        check("pred_src", imem_req_addr, 32'h10);
        fetch_simple(1, 32'h80, dummy);
        check("pred_target", imem_req_addr, 32'h80);

        // Redirect in HOLD wins over decode accept and prediction
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, a);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, a);
        step(0, 0, 1, 32'h300, 1, 32'h400, 1, a);
        check("hold_redirect", imem_req_addr, 32'h300);

        // Redirect while waiting: the late response is dropped
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, a);
        step(0, 0, 1, 32'h200, 0, 32'h0, 0, a);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, a);
        step(0, 1, 0, 32'h0, 0, 32'h0, 1, a);
        check("drain_if_valid", 32'(if_valid), 32'd0);
        check("drain_req_addr", imem_req_addr, 32'h200);
        check("drain_req_valid", 32'(imem_req_valid), 32'd1);

        // PC+4 wraps from the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, a);
        check("wrap_src", imem_req_addr, 32'hFFFF_FFFC);
        fetch_simple(0, 32'h0, dummy);
        check("wrap_dst", imem_req_addr, 32'h0000_0000);

        // Reset during WAIT; the stale response after release is ignored
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, a);
        rst = 1'b1;
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, a);
        rst = 1'b0;
        step(0, 1, 0, 32'h0, 0, 32'h0, 1, a);
        check("rst_late_if_valid", 32'(if_valid), 32'd0);
        check("rst_late_addr", imem_req_addr, RV);
        step(0, 0, 0, 32'h0, 0, 32'h0, 1, a);
        check("rst_late_if_valid2", 32'(if_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                mem_pend = 0;
                step(0, 0, 0, 32'h0, 0, 32'h0, 0, a);
                rst = 1'b0;
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0), $urandom,
                     1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), a);
            end
        end
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, a);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, first fetch address; bits [1:0] SHALL be zero.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 evaluated_branch_mispredicted  in  1  redirect request from execute.
REQ-007 evaluated_branch_result  in  XLEN  correct target on redirect.
REQ-008 predicted_branch_taken  in  1  predictor verdict for current if_pc.
REQ-009 predicted_branch_target  in  XLEN  predicted target for current if_pc.
REQ-010 imem_req_valid  out  1  fetch request valid.
REQ-011 imem_req_addr  out  XLEN  fetch address, equal to the PC register.
REQ-012 imem_req_ready  in  1  memory accepts request this cycle.
REQ-013 imem_resp_valid  in  1  one response per accepted request, in order.
REQ-014 imem_resp_data  in  32  fetched instruction.
REQ-015 if_valid  out  1  instruction held for decode.
REQ-016 if_pc  out  XLEN  PC of held instruction.
REQ-017 if_instr  out  32  held instruction.
REQ-018 if_ready  in  1  decode accepts held instruction.

Function
REQ-019 SHALL implement states REQ, WAIT, HOLD, DRAIN.
REQ-020 REQ: imem_req_valid=1; on imem_req_ready -> WAIT; otherwise stay in REQ.
REQ-021 WAIT: on imem_resp_valid, register data into if_instr and PC into if_pc, then -> HOLD; if_valid=1 from the next cycle; 1-cycle response-to-if_valid latency.
REQ-022 HOLD: if_valid=1; on if_ready, PC <= selected next PC, then -> REQ.
REQ-023 DRAIN: on imem_resp_valid, discard the response and -> REQ; if_valid stays 0.
REQ-024 Next-PC priority SHALL be: mispredict -> evaluated_branch_result; else predicted_branch_taken -> predicted_branch_target; else PC+4.
REQ-025 PC+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x00000000).
REQ-026 Every value loaded into PC SHALL have bits [1:0] forced to 0.
REQ-027 The predictor inputs SHALL be sampled only at HOLD with if_ready=1; they are ignored in all other cases.
REQ-028 A mispredict in any state SHALL load PC <= evaluated_branch_result in that cycle.
REQ-029 Mispredict in REQ without accept: stay REQ, with the new address on the next cycle; this is the only case where imem_req_addr changes while valid=1 and not accepted.
REQ-030 Mispredict in REQ with accept same cycle -> DRAIN.
REQ-031 Mispredict in WAIT without resp -> DRAIN; with resp same cycle -> response discarded, -> REQ.
REQ-032 Mispredict in HOLD: if_valid=0 next cycle, -> REQ; mispredict SHALL take priority over a simultaneous if_ready.
REQ-033 Mispredict in DRAIN: update PC, stay DRAIN until the pending response arrives.
REQ-034 if_pc and if_instr SHALL stay stable while if_valid=1 and if_ready=0.
REQ-035 At most one imem request SHALL be outstanding.

Reset
REQ-036 While rst=1: state=REQ, PC=RESET_VECTOR, if_valid=0, if_pc=0, if_instr=0; imem_req_valid SHALL be 0 while rst is asserted.
REQ-037 On the first edge after rst deasserts, imem_req_valid=1 with imem_req_addr=RESET_VECTOR.
REQ-038 Reset mid-transaction SHALL abandon any outstanding response; the memory side is reset by the same rst.

Structure
REQ-039 A shared package rv32i_pkg SHALL hold the fetch_state_t enum and the default XLEN constant.
REQ-040 Next-PC selection SHALL instantiate the existing pc_select sub-module; the PC register, the +4 adder and the FSM live in fetch_controller.

Verification
REQ-041 Reset then ready=1, resp after 1 cycle, if_ready=1 -> requests go to 0x0, 0x4, 0x8; if_pc matches each; one fetch per 3 cycles.
REQ-042 HOLD at if_pc=0x10 with predicted_taken=1, target=0x80, if_ready=1 -> next imem_req_addr=0x80.
REQ-043 In WAIT, mispredict to 0x200, response arrives 2 cycles later -> response dropped, if_valid never 1 for it, next request at 0x200.
REQ-044 In HOLD, mispredict to 0x300 together with if_ready=1 and predicted_taken=1 -> PC=0x300, predictor ignored.
REQ-045 PC=0xFFFFFFFC accepted with no prediction -> next request at 0x00000000.
REQ-046 rst asserted in WAIT, late response arriving after release -> ignored; if_valid=0; first request at RESET_VECTOR.
